if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the program counter and drives the instruction-cache read port. It presents either a fetched instruction with its PC+4, or a NOP bubble (32'h0) when no instruction is available. It also handles load-use stalls, branch redirects resolved in ID, and multi-cycle I-cache misses, including a redirect that arrives while a miss is outstanding.

---
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, I-cache read port, redirect and miss handling
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        Branch_taken,
   input  logic [31:0] branch_target,
   output logic        ICACHE_ren,
   output logic        ICACHE_wen,
   output logic [29:0] ICACHE_addr,
   input  logic [31:0] ICACHE_rdata,
   input  logic        ICACHE_stall,
   output logic [31:0] INST_out,
   output logic [31:0] PC_plus_4_out,
   output logic        IF_valid,
   output logic        fetch_stall
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] tgt_aligned;
   logic [31:0] pc_inc;

   assign tgt_aligned = branch_target & 32'hFFFF_FFFC;
   assign pc_inc      = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      tgt_d         = tgt_q;
      ICACHE_ren    = 1'b0;
      INST_out      = 32'h0;
      PC_plus_4_out = 32'h0;
      IF_valid      = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ICACHE_ren = 1'b1;
            if (!ICACHE_stall) begin
               INST_out      = ICACHE_rdata;
               PC_plus_4_out = pc_inc;
               IF_valid      = 1'b1;
               if (Branch_taken) begin
                  pc_d = tgt_aligned;
               end else if (!stall) begin
                  pc_d = pc_inc;
               end
            end else if (Branch_taken) begin
               // Miss in flight: park the target until the cache lets go of the stale address
               tgt_d   = tgt_aligned;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            ICACHE_ren = 1'b1;
            if (Branch_taken) begin
               tgt_d = tgt_aligned;
            end
            if (!ICACHE_stall) begin
               pc_d    = Branch_taken ? tgt_aligned : tgt_q;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ICACHE_wen  = 1'b0;
   assign ICACHE_addr = pc_q[31:2];
   assign fetch_stall = ICACHE_ren & ICACHE_stall;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed vector table plus randomized model comparison
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        Branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        ICACHE_ren;
   logic        ICACHE_wen;
   logic [29:0] ICACHE_addr;
   logic [31:0] ICACHE_rdata = 32'h0;
   logic        ICACHE_stall = 1'b0;
   logic [31:0] INST_out;
   logic [31:0] PC_plus_4_out;
   logic        IF_valid;
   logic        fetch_stall;

   int total = 0;
   int bad   = 0;

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .Branch_taken (Branch_taken),
      .branch_target(branch_target),
      .ICACHE_ren   (ICACHE_ren),
      .ICACHE_wen   (ICACHE_wen),
      .ICACHE_addr  (ICACHE_addr),
      .ICACHE_rdata (ICACHE_rdata),
      .ICACHE_stall (ICACHE_stall),
      .INST_out     (INST_out),
      .PC_plus_4_out(PC_plus_4_out),
      .IF_valid     (IF_valid),
      .fetch_stall  (fetch_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stl;
      logic        bt;
      logic [31:0] tgt;
      logic        ics;
      logic        ren;
      logic [29:0] addr;
      logic        vld;
      logic [31:0] pc4;
   } vec_t;

   vec_t tbl [28];

   function automatic vec_t mk(input logic stl, input logic bt, input logic [31:0] tgt,
                               input logic ics, input logic ren, input logic [29:0] addr,
                               input logic vld, input logic [31:0] pc4);
      vec_t v;
      v.stl = stl; v.bt = bt; v.tgt = tgt; v.ics = ics;
      v.ren = ren; v.addr = addr; v.vld = vld; v.pc4 = pc4;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ren, input logic [29:0] addr,
                            input logic vld, input logic [31:0] inst, input logic [31:0] pc4,
                            input logic fs);
      chk({tag, " ren"},   {31'h0, ICACHE_ren}, {31'h0, ren});
      chk({tag, " wen"},   {31'h0, ICACHE_wen}, 32'h0);
      chk({tag, " addr"},  {2'b00, ICACHE_addr}, {2'b00, addr});
      chk({tag, " valid"}, {31'h0, IF_valid}, {31'h0, vld});
      chk({tag, " inst"},  INST_out, inst);
      chk({tag, " pc4"},   PC_plus_4_out, pc4);
      chk({tag, " fstall"}, {31'h0, fetch_stall}, {31'h0, fs});
   endtask

   // Reference model: a running flag, the fetch PC and a list of redirects seen during a miss
   bit          m_run;
   logic [31:0] m_pc;
   logic [31:0] redir_q [$];

   task automatic model_reset();
      m_run = 1'b0;
      m_pc  = RST_PC;
      redir_q.delete();
   endtask

   task automatic model_cycle(input logic stl, input logic bt, input logic [31:0] tgt,
                              input logic ics, input logic [31:0] rd,
                              output logic ren, output logic [29:0] addr, output logic vld,
                              output logic [31:0] inst, output logic [31:0] pc4);
      logic [31:0] al;
      al   = {tgt[31:2], 2'b00};
      ren  = m_run;
      addr = m_pc[31:2];
      vld  = 1'b0;
      inst = 32'h0;
      pc4  = 32'h0;
      if (!m_run) begin
         m_run = 1'b1;
      end else if (redir_q.size() > 0) begin
         if (bt) redir_q.push_back(al);
         if (!ics) begin
            m_pc = redir_q[$];
            redir_q.delete();
         end
      end else if (!ics) begin
         vld  = 1'b1;
         inst = rd;
         pc4  = m_pc + 32'd4;
         if (bt)        m_pc = al;
         else if (!stl) m_pc = m_pc + 32'd4;
      end else if (bt) begin
         redir_q.push_back(al);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        e_ren, e_vld;
      logic [29:0] e_addr;
      logic [31:0] e_inst, e_pc4;

      tbl[0]  = mk(0, 1, 32'h500, 0, 0, 30'h0, 0, 32'h0);
      tbl[1]  = mk(0, 0, 32'h0,   0, 1, 30'h0, 1, 32'h4);
      tbl[2]  = mk(0, 0, 32'h0,   0, 1, 30'h1, 1, 32'h8);
      tbl[3]  = mk(0, 0, 32'h0,   0, 1, 30'h2, 1, 32'hC);
      tbl[4]  = mk(0, 0, 32'h0,   0, 1, 30'h3, 1, 32'h10);
      tbl[5]  = mk(1, 0, 32'h0,   0, 1, 30'h4, 1, 32'h14);
      tbl[6]  = mk(1, 0, 32'h0,   0, 1, 30'h4, 1, 32'h14);
      tbl[7]  = mk(0, 0, 32'h0,   0, 1, 30'h4, 1, 32'h14);
      tbl[8]  = mk(0, 1, 32'h20,  0, 1, 30'h5, 1, 32'h18);
      tbl[9]  = mk(0, 0, 32'h0,   1, 1, 30'h8, 0, 32'h0);
      tbl[10] = mk(0, 0, 32'h0,   1, 1, 30'h8, 0, 32'h0);
      tbl[11] = mk(0, 0, 32'h0,   1, 1, 30'h8, 0, 32'h0);
      tbl[12] = mk(0, 1, 32'h40,  0, 1, 30'h8, 1, 32'h24);
      tbl[13] = mk(0, 0, 32'h0,   1, 1, 30'h10, 0, 32'h0);
      tbl[14] = mk(0, 1, 32'h100, 1, 1, 30'h10, 0, 32'h0);
      tbl[15] = mk(0, 0, 32'h0,   1, 1, 30'h10, 0, 32'h0);
      tbl[16] = mk(0, 0, 32'h0,   1, 1, 30'h10, 0, 32'h0);
      tbl[17] = mk(0, 0, 32'h0,   0, 1, 30'h10, 0, 32'h0);
      tbl[18] = mk(0, 1, 32'h40,  0, 1, 30'h40, 1, 32'h104);
      tbl[19] = mk(0, 0, 32'h0,   1, 1, 30'h10, 0, 32'h0);
      tbl[20] = mk(0, 1, 32'h100, 1, 1, 30'h10, 0, 32'h0);
      tbl[21] = mk(0, 1, 32'h200, 1, 1, 30'h10, 0, 32'h0);
      tbl[22] = mk(0, 0, 32'h0,   1, 1, 30'h10, 0, 32'h0);
      tbl[23] = mk(0, 0, 32'h0,   0, 1, 30'h10, 0, 32'h0);
      tbl[24] = mk(1, 1, 32'h103, 0, 1, 30'h80, 1, 32'h204);
      tbl[25] = mk(0, 1, 32'hFFFF_FFFC, 0, 1, 30'h40, 1, 32'h104);
      tbl[26] = mk(0, 0, 32'h0,   0, 1, 30'h3FFF_FFFF, 1, 32'h0);
      tbl[27] = mk(0, 0, 32'h0,   0, 1, 30'h0, 1, 32'h4);

      #1;
      check_all("reset", 1'b0, RST_PC[31:2], 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         rd            = (i == 1) ? 32'h2008_0005 : 32'h2008_0005 + i * 32'h111;
         stall         = tbl[i].stl;
         Branch_taken  = tbl[i].bt;
         branch_target = tbl[i].tgt;
         ICACHE_stall  = tbl[i].ics;
         ICACHE_rdata  = rd;
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].ren, tbl[i].addr, tbl[i].vld,
                   tbl[i].vld ? rd : 32'h0, tbl[i].pc4, tbl[i].ren & tbl[i].ics);
      end

      // Reset while draining a redirected miss: outputs drop at once, pending target is lost
      @(negedge clk);
      stall = 1'b0; Branch_taken = 1'b1; branch_target = 32'h300; ICACHE_stall = 1'b1;
      #1 check_all("drain_enter", 1'b1, 30'h1, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      Branch_taken = 1'b0;
      #1 check_all("drain_hold", 1'b1, 30'h1, 1'b0, 32'h0, 32'h0, 1'b1);
      #2 rst = 1'b1;
      #1 check_all("drain_rst", 1'b0, RST_PC[31:2], 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      ICACHE_stall = 1'b0;
      ICACHE_rdata = 32'hCAFE_0001;
      @(negedge clk);
      #1 check_all("post_rst_idle", 1'b0, RST_PC[31:2], 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      #1 check_all("post_rst_fetch", 1'b1, RST_PC[31:2], 1'b1, 32'hCAFE_0001, RST_PC + 32'd4, 1'b0);
      @(negedge clk);
      #1 check_all("post_rst_next", 1'b1, RST_PC[31:2] + 30'd1, 1'b1, 32'hCAFE_0001, RST_PC + 32'd8, 1'b0);

      // Randomized run against the model, with occasional resets
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (rst) rst = ($urandom_range(0, 1) == 0);
         else     rst = ($urandom_range(0, 199) == 0);
         stall         = ($urandom_range(0, 4) == 0);
         Branch_taken  = ($urandom_range(0, 4) == 0);
         branch_target = $urandom;
         ICACHE_stall  = ($urandom_range(0, 2) == 0);
         ICACHE_rdata  = $urandom;
         if (rst) begin
            model_reset();
            e_ren = 1'b0; e_addr = RST_PC[31:2]; e_vld = 1'b0; e_inst = 32'h0; e_pc4 = 32'h0;
         end else begin
            model_cycle(stall, Branch_taken, branch_target, ICACHE_stall, ICACHE_rdata,
                        e_ren, e_addr, e_vld, e_inst, e_pc4);
         end
         #1 check_all("rnd", e_ren, e_addr, e_vld, e_inst, e_pc4, e_ren & ICACHE_stall);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
